// File: rtl/fir_pkg.sv
// Shared types and helpers for the sample pipeline back end.
package fir_pkg;

  typedef enum logic {
    UNPK_IDLE  = 1'b0,
    UNPK_SHIFT = 1'b1
  } unpack_state_t;

  // Width of a word index into an n-word bundle; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear takes effect
// before a same-cycle increment, so clr & inc yields a count of one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] base;

  // Value the increment applies to: zero when clearing, else current count.
  always_comb begin
    base = clr ? '0 : count;
  end

  // Count register, stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (base != '1))
      count <= base + ONE;
    else
      count <= base;
  end

endmodule

// File: rtl/sample_unpacker.sv
// Serialises a packed bundle of DATA_COUNT words onto a ready/valid stream,
// word 0 first. Bundles arriving while a bundle is still held are dropped
// and counted, since the upstream bus cannot be stalled.
module sample_unpacker
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_COUNT = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*DATA_COUNT-1:0] data_in,
  input  logic                             valid_in,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             overflow,
  output logic [CNT_WIDTH-1:0]             drop_count,
  input  logic                             ovf_clr
);

  localparam int                IDX_W    = idx_width(DATA_COUNT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_COUNT - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  unpack_state_t                    state;
  logic [IDX_W-1:0]                 index;
  logic [DATA_WIDTH*DATA_COUNT-1:0] held;
  logic                             accept;
  logic                             drop;

  // Output word and handshake qualifiers, all decoded from registers.
  always_comb begin
    out_valid = (state == UNPK_SHIFT);
    out_last  = out_valid && (index == LAST_IDX);
    out_data  = held[DATA_WIDTH*int'(index) +: DATA_WIDTH];
    in_ready  = (state == UNPK_IDLE) || (out_valid && out_ready && out_last);
    accept    = valid_in && in_ready;
    drop      = valid_in && !in_ready;
  end

  // Bundle capture and word sequencing; a new bundle may replace the
  // held one on the cycle its last word is taken, giving no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNPK_IDLE;
      index <= '0;
      held  <= '0;
    end else if (accept) begin
      held  <= data_in;
      index <= '0;
      state <= UNPK_SHIFT;
    end else if (out_valid && out_ready) begin
      if (out_last)
        state <= UNPK_IDLE;
      else
        index <= index + IDX_ONE;
    end
  end

  // Sticky overflow flag; a same-cycle drop overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (ovf_clr),
    .inc   (drop),
    .count (drop_count)
  );

endmodule
